tb_mem_initiator: RTL and testbench



---
 rtl/tb_mem_pkg.sv | 21 ++
 rtl/tb_sync_fifo.sv | 56 +++++
 rtl/tb_mem_initiator.sv | 141 ++++++++++++++
 tb/tb_tb_mem_initiator.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tb_mem_pkg.sv
// Shared types for the data-memory initiator: queued command and buffered response.
package tb_mem_pkg;

  typedef struct packed {
    logic        we;
    logic [31:0] rdata;
  } rsp_entry_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } cmd_entry_t;

  // Width of a counter that must hold every value 0..depth.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/tb_sync_fifo.sv
// Synchronous FIFO with registered occupancy; push and pop may coincide even when full.
module tb_sync_fifo
  import tb_mem_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = logic [31:0]
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  T                          wdata,
  input  logic                      pop,
  output T                          rdata,
  output logic                      full,
  output logic                      empty,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_w(DEPTH);

  T              mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/tb_mem_initiator.sv
// Requester end of the req/gnt/rvalid data-memory port: in-order issue with
// credit-limited outstanding transactions and a response buffer for unstoppable rvalid.
module tb_mem_initiator
  import tb_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [31:0] cmd_addr_i,
  input  logic        cmd_we_i,
  input  logic [3:0]  cmd_be_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_we_o,
  output logic [31:0] rsp_rdata_o,
  output logic        err_o
);

  localparam int CW = cnt_w(DEPTH);

  // Handshakes: a command transfers on cmd_valid_i && cmd_ready_o, a response on
  // rsp_valid_o && rsp_ready_i, a bus request on data_req_o && data_gnt_i; once
  // raised, data_req_o and its payload hold until granted.

  cmd_entry_t      cmd_q;
  logic            cmd_q_valid;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   buffered;
  logic [CW-1:0]   tag_count;
  logic            issue;
  logic            accept;
  logic            rvalid_ok;
  logic            rsp_pop;
  logic            credit_ok;
  logic            tag_head_we;
  logic            tag_full;
  logic            tag_empty;
  logic            rsp_full;
  logic            rsp_empty;
  rsp_entry_t      rsp_push_entry;
  rsp_entry_t      rsp_head;

  // Credits only return when responses drain, so a raised request never drops.
  assign credit_ok   = ({1'b0, inflight} + {1'b0, buffered}) < (CW + 1)'(DEPTH);
  assign data_req_o  = cmd_q_valid && credit_ok;
  assign issue       = data_req_o && data_gnt_i;
  assign cmd_ready_o = !rst_i && (!cmd_q_valid || issue);
  assign accept      = cmd_valid_i && cmd_ready_o;

  assign data_addr_o  = cmd_q.addr;
  assign data_we_o    = cmd_q.we;
  assign data_be_o    = cmd_q.be;
  assign data_wdata_o = cmd_q.wdata;

  // A response with nothing in flight is spurious: flag it and drop it.
  assign rvalid_ok      = data_rvalid_i && (inflight != '0);
  assign rsp_push_entry = '{we: tag_head_we, rdata: data_rdata_i};

  assign rsp_valid_o = !rsp_empty;
  assign rsp_pop     = rsp_valid_o && rsp_ready_i;
  assign rsp_we_o    = rsp_valid_o && rsp_head.we;
  assign rsp_rdata_o = rsp_valid_o ? rsp_head.rdata : 32'h0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmd_q       <= '0;
      cmd_q_valid <= 1'b0;
    end else if (accept) begin
      cmd_q       <= '{addr: cmd_addr_i, we: cmd_we_i, be: cmd_be_i, wdata: cmd_wdata_i};
      cmd_q_valid <= 1'b1;
    end else if (issue) begin
      cmd_q_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight <= '0;
      err_o    <= 1'b0;
    end else begin
      if (issue && !rvalid_ok)      inflight <= inflight + CW'(1);
      else if (rvalid_ok && !issue) inflight <= inflight - CW'(1);
      if (data_rvalid_i && (inflight == '0)) err_o <= 1'b1;
    end
  end

  // Tag FIFO remembers we per granted transaction until its rvalid.
  tb_sync_fifo #(
    .DEPTH (DEPTH),
    .T     (logic)
  ) u_tag_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (issue),
    .wdata (cmd_q.we),
    .pop   (rvalid_ok),
    .rdata (tag_head_we),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  tb_sync_fifo #(
    .DEPTH (DEPTH),
    .T     (rsp_entry_t)
  ) u_rsp_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (rvalid_ok),
    .wdata (rsp_push_entry),
    .pop   (rsp_pop),
    .rdata (rsp_head),
    .full  (rsp_full),
    .empty (rsp_empty),
    .count (buffered)
  );

  a_credit_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    ({1'b0, inflight} + {1'b0, buffered}) <= (CW + 1)'(DEPTH));
  a_tag_tracks_inflight: assert property (@(posedge clk_i) disable iff (rst_i)
    tag_count == inflight);
  a_tag_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(tag_full && issue && !rvalid_ok));
  a_tag_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(rvalid_ok && tag_empty));
  a_rsp_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(rsp_full && rvalid_ok && !rsp_pop));

endmodule

// File: tb/tb_tb_mem_initiator.sv
// Directed bench for tb_mem_initiator: a queue-level reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_tb_mem_initiator;
  import tb_mem_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic        cmd_we = 1'b0;
  logic [3:0]  cmd_be = '0;
  logic [31:0] cmd_wdata = '0;
  logic        data_req;
  logic        data_gnt = 1'b0;
  logic [31:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic        data_rvalid = 1'b0;
  logic [31:0] data_rdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_we;
  logic [31:0] rsp_rdata;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  // Clock / reset
  always #5 clk = ~clk;

  tb_mem_initiator #(.DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_addr_i    (cmd_addr),
    .cmd_we_i      (cmd_we),
    .cmd_be_i      (cmd_be),
    .cmd_wdata_i   (cmd_wdata),
    .data_req_o    (data_req),
    .data_gnt_i    (data_gnt),
    .data_addr_o   (data_addr),
    .data_we_o     (data_we),
    .data_be_o     (data_be),
    .data_wdata_o  (data_wdata),
    .data_rvalid_i (data_rvalid),
    .data_rdata_i  (data_rdata),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_we_o      (rsp_we),
    .rsp_rdata_o   (rsp_rdata),
    .err_o         (err)
  );

  // Reference model: pending command, outstanding write-flags, buffered responses.
  cmd_entry_t  m_cmd[$];
  logic        m_tags[$];
  logic [32:0] exp_q[$];
  logic        m_err = 1'b0;
  bit          mu_issue;
  bit          mu_accept;
  cmd_entry_t  mu_cmd;

  function automatic logic exp_req_f();
    return (m_cmd.size() != 0) && ((m_tags.size() + exp_q.size()) < DEPTH);
  endfunction

  function automatic logic exp_ready_f();
    return !rst && ((m_cmd.size() == 0) || (exp_req_f() && data_gnt));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_cmd.delete();
      m_tags.delete();
      exp_q.delete();
      m_err = 1'b0;
    end else begin
      mu_issue  = exp_req_f() && data_gnt;
      mu_accept = cmd_valid && exp_ready_f();
      if (rsp_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (data_rvalid) begin
        if (m_tags.size() == 0) m_err = 1'b1;
        else exp_q.push_back({m_tags.pop_front(), data_rdata});
      end
      if (mu_issue) begin
        m_tags.push_back(m_cmd[0].we);
        void'(m_cmd.pop_front());
      end
      if (mu_accept) begin
        mu_cmd.addr  = cmd_addr;
        mu_cmd.we    = cmd_we;
        mu_cmd.be    = cmd_be;
        mu_cmd.wdata = cmd_wdata;
        m_cmd.push_back(mu_cmd);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: compare DUT outputs to the model on every cycle mid-period.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_cmd_ready", 32'(cmd_ready), 32'(exp_ready_f()));
      chk("m_data_req", 32'(data_req), 32'(exp_req_f()));
      if (exp_req_f()) begin
        chk("m_data_addr", data_addr, m_cmd[0].addr);
        chk("m_data_we", 32'(data_we), 32'(m_cmd[0].we));
        chk("m_data_be", 32'(data_be), 32'(m_cmd[0].be));
        chk("m_data_wdata", data_wdata, m_cmd[0].wdata);
      end
      chk("m_rsp_valid", 32'(rsp_valid), 32'(exp_q.size() != 0));
      chk("m_rsp_we", 32'(rsp_we), (exp_q.size() != 0) ? 32'(exp_q[0][32]) : 32'h0);
      chk("m_rsp_rdata", rsp_rdata, (exp_q.size() != 0) ? exp_q[0][31:0] : 32'h0);
      chk("m_err", 32'(err), 32'(m_err));
    end
  end

  // Driver tasks
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input logic cv, input logic [31:0] a, input logic w,
                       input logic [3:0] b, input logic [31:0] wd, input logic g,
                       input logic rv, input logic [31:0] rd, input logic rr);
    cmd_valid   = cv;
    cmd_addr    = a;
    cmd_we      = w;
    cmd_be      = b;
    cmd_wdata   = wd;
    data_gnt    = g;
    data_rvalid = rv;
    data_rdata  = rd;
    rsp_ready   = rr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      nxt();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (2) nxt();
    chk_en = 1'b1;
    mid();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    chk("rst_data_req", 32'(data_req), 32'h0);
    chk("rst_data_addr", data_addr, 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    nxt();
    rst = 1'b0;

    // Single read, granted immediately, answered one cycle later
    drive(1, 32'h100, 0, 4'hF, 0, 1, 0, 0, 1); mid();
    chk("t1_cmd_ready", 32'(cmd_ready), 32'h1); nxt();
    drive(0, 0, 0, 0, 0, 1, 0, 0, 1); mid();
    chk("t1_req", 32'(data_req), 32'h1);
    chk("t1_addr", data_addr, 32'h100); nxt();
    drive(0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 1); mid();
    chk("t1_rsp_not_yet", 32'(rsp_valid), 32'h0); nxt();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); mid();
    chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t1_rsp_we", 32'(rsp_we), 32'h0);
    chk("t1_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("t1_err", 32'(err), 32'h0); nxt();
    mid();
    chk("t1_rsp_drained", 32'(rsp_valid), 32'h0);
    idle(2);

    // Three back-to-back writes, rvalid two cycles after each grant
    drive(1, 32'h0, 1, 4'hF, 32'h11, 1, 0, 0, 1); mid();
    chk("t2_ready0", 32'(cmd_ready), 32'h1); nxt();
    drive(1, 32'h4, 1, 4'hF, 32'h22, 1, 0, 0, 1); mid();
    chk("t2_addr0", data_addr, 32'h0); nxt();
    drive(1, 32'h8, 1, 4'hF, 32'h33, 1, 0, 0, 1); mid();
    chk("t2_addr1", data_addr, 32'h4); nxt();
    drive(0, 0, 0, 0, 0, 1, 1, 32'hA0, 1); mid();
    chk("t2_req_blocked", 32'(data_req), 32'h0);
    chk("t2_ready_blocked", 32'(cmd_ready), 32'h0); nxt();
    drive(0, 0, 0, 0, 0, 1, 1, 32'hA1, 1); mid();
    chk("t2_rsp0_we", 32'(rsp_we), 32'h1);
    chk("t2_rsp0_rdata", rsp_rdata, 32'hA0); nxt();
    drive(0, 0, 0, 0, 0, 1, 0, 0, 1); mid();
    chk("t2_req2", 32'(data_req), 32'h1);
    chk("t2_addr2", data_addr, 32'h8); nxt();
    drive(0, 0, 0, 0, 0, 1, 0, 0, 1); nxt();
    drive(0, 0, 0, 0, 0, 1, 1, 32'hA2, 1); nxt();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); mid();
    chk("t2_rsp2_rdata", rsp_rdata, 32'hA2); nxt();
    idle(2);

    // Grant withheld three cycles: request and address must hold
    drive(1, 32'h200, 0, 4'hF, 0, 0, 0, 0, 1); mid();
    chk("t3_ready", 32'(cmd_ready), 32'h1); nxt();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h300, 0, 4'h3, 0, 0, 0, 0, 1); mid();
      chk("t3_req_hold", 32'(data_req), 32'h1);
      chk("t3_addr_hold", data_addr, 32'h200);
      chk("t3_ready_low", 32'(cmd_ready), 32'h0); nxt();
    end
    drive(1, 32'h300, 0, 4'h3, 0, 1, 0, 0, 1); mid();
    chk("t3_gnt_addr", data_addr, 32'h200);
    chk("t3_gnt_ready", 32'(cmd_ready), 32'h1); nxt();
    drive(0, 0, 0, 0, 0, 1, 1, 32'h12345678, 1); mid();
    chk("t3_addr_next", data_addr, 32'h300); nxt();
    drive(0, 0, 0, 0, 0, 0, 1, 32'h00009ABC, 1); mid();
    chk("t3_rsp0", rsp_rdata, 32'h12345678); nxt();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); mid();
    chk("t3_rsp1", rsp_rdata, 32'h00009ABC); nxt();
    idle(2);

    // Consumer stalled: response buffer fills and blocks the third request
    drive(1, 32'h10, 0, 4'hF, 0, 1, 0, 0, 0); nxt();
    drive(1, 32'h14, 0, 4'hF, 0, 1, 0, 0, 0); nxt();
    drive(1, 32'h18, 0, 4'hF, 0, 1, 1, 32'h10AA, 0); nxt();
    drive(0, 0, 0, 0, 0, 1, 1, 32'h14AA, 0); mid();
    chk("t4_req_c3", 32'(data_req), 32'h0); nxt();
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0); mid();
    chk("t4_full_req", 32'(data_req), 32'h0);
    chk("t4_head", rsp_rdata, 32'h10AA); nxt();
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0); mid();
    chk("t4_still_blocked", 32'(data_req), 32'h0); nxt();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); mid();
    chk("t4_pop_cycle_req", 32'(data_req), 32'h0); nxt();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); mid();
    chk("t4_req_back", 32'(data_req), 32'h1);
    chk("t4_req_addr", data_addr, 32'h18);
    chk("t4_head2", rsp_rdata, 32'h14AA); nxt();
    drive(0, 0, 0, 0, 0, 1, 0, 0, 1); nxt();
    drive(0, 0, 0, 0, 0, 0, 1, 32'h18AA, 1); nxt();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); mid();
    chk("t4_last", rsp_rdata, 32'h18AA); nxt();
    idle(2);

    // Spurious rvalid with nothing outstanding
    drive(0, 0, 0, 0, 0, 0, 1, 32'h55, 1); mid();
    chk("t5_err_before", 32'(err), 32'h0); nxt();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); mid();
    chk("t5_err_set", 32'(err), 32'h1);
    chk("t5_no_rsp", 32'(rsp_valid), 32'h0); nxt();
    mid();
    chk("t5_err_sticky", 32'(err), 32'h1); nxt();

    // Reset with one transaction granted and one response buffered
    drive(1, 32'h40, 0, 4'hF, 0, 1, 0, 0, 0); nxt();
    drive(1, 32'h44, 0, 4'hF, 0, 1, 0, 0, 0); nxt();
    drive(0, 0, 0, 0, 0, 1, 1, 32'h40AA, 0); nxt();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1; mid();
    chk("t6_rst_ready", 32'(cmd_ready), 32'h0);
    chk("t6_pre_rsp", 32'(rsp_valid), 32'h1); nxt();
    rst = 1'b0; mid();
    chk("t6_req", 32'(data_req), 32'h0);
    chk("t6_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("t6_rsp_rdata", rsp_rdata, 32'h0);
    chk("t6_err_clr", 32'(err), 32'h0);
    chk("t6_addr", data_addr, 32'h0); nxt();
    drive(0, 0, 0, 0, 0, 0, 1, 32'h44AA, 1); mid();
    chk("t6_err_late_before", 32'(err), 32'h0); nxt();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); mid();
    chk("t6_err_late", 32'(err), 32'h1);
    chk("t6_no_rsp", 32'(rsp_valid), 32'h0); nxt();
    idle(2);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
